// File: rtl/md5_result_tx_arbiter.sv
// Round-robin collector of MD5 core match reports, framed as A5 / id / candidate bytes / optional XOR sum.
// Build option: define MD5_RESULT_TX_CHECKSUM_EN to append the checksum byte.
module md5_result_tx_arbiter #(
  parameter int NCORES = 4,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES*WORD_W-1:0] cand,
  output logic [NCORES-1:0]        ack,
  input  logic                     rewind_usart,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     tx_led
);

  localparam int NB    = WORD_W / 8;
  localparam int PTR_W = $clog2(NCORES);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR, ID, DATA, SUM} state_t;

  state_t              state, state_n;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
  logic                store_valid, store_valid_n;
  logic [PTR_W-1:0]    store_id, store_id_n;
  logic [WORD_W-1:0]   store_cand, store_cand_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [7:0]          tx_data_n;
  logic                tx_valid_n;
  logic                tx_led_n;
  logic [NCORES-1:0]   ack_n;
  logic                accept;
  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;
  logic [7:0]          id_byte;
  logic [7:0]          first_data;
  logic [7:0]          next_data;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
  logic [7:0]          csum, csum_n;
`endif

  assign accept     = tx_valid && tx_ready;
  assign busy       = (state != IDLE);
  assign id_byte    = 8'(store_id);
  assign first_data = store_cand[{CNT_W'(NB - 1), 3'b000} +: 8];
  assign next_data  = store_cand[{cnt - 1'b1, 3'b000} +: 8];

  // First requesting core at or after rr_ptr, wrapping around the core array.
  always_comb begin
    int j;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < NCORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NCORES) j = j - NCORES;
      if (!grant_found && req[j]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    store_valid_n = store_valid;
    store_id_n    = store_id;
    store_cand_n  = store_cand;
    cnt_n         = cnt;
    tx_data_n     = tx_data;
    tx_valid_n    = tx_valid;
    tx_led_n      = tx_led;
    ack_n         = '0;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
    csum_n        = csum;
`endif
    case (state)
      IDLE: begin
        // A replay takes priority; a coincident request simply stays pending.
        if (rewind_usart && store_valid) begin
          state_n    = HDR;
          tx_data_n  = HDR_BYTE;
          tx_valid_n = 1'b1;
        end else if (grant_found) begin
          state_n          = HDR;
          tx_data_n        = HDR_BYTE;
          tx_valid_n       = 1'b1;
          store_valid_n    = 1'b1;
          store_id_n       = grant_idx;
          store_cand_n     = cand[grant_idx*WORD_W +: WORD_W];
          ack_n[grant_idx] = 1'b1;
          rr_ptr_n         = (grant_idx == PTR_W'(NCORES - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      HDR: begin
        if (accept) begin
          state_n   = ID;
          tx_data_n = id_byte;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
          csum_n    = id_byte;
`endif
        end
      end
      ID: begin
        if (accept) begin
          state_n   = DATA;
          cnt_n     = CNT_W'(NB - 1);
          tx_data_n = first_data;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
          csum_n    = csum ^ first_data;
`endif
        end
      end
      DATA: begin
        if (accept) begin
          if (cnt == '0) begin
`ifdef MD5_RESULT_TX_CHECKSUM_EN
            state_n    = SUM;
            tx_data_n  = csum;
`else
            state_n    = IDLE;
            tx_data_n  = '0;
            tx_valid_n = 1'b0;
            tx_led_n   = ~tx_led;
`endif
          end else begin
            cnt_n     = cnt - 1'b1;
            tx_data_n = next_data;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
            csum_n    = csum ^ next_data;
`endif
          end
        end
      end
`ifdef MD5_RESULT_TX_CHECKSUM_EN
      SUM: begin
        if (accept) begin
          state_n    = IDLE;
          tx_data_n  = '0;
          tx_valid_n = 1'b0;
          tx_led_n   = ~tx_led;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      store_valid <= 1'b0;
      store_id    <= '0;
      store_cand  <= '0;
      cnt         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_led      <= 1'b0;
      ack         <= '0;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      store_valid <= store_valid_n;
      store_id    <= store_id_n;
      store_cand  <= store_cand_n;
      cnt         <= cnt_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      tx_led      <= tx_led_n;
      ack         <= ack_n;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
      csum        <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_md5_result_tx_arbiter.sv
// Directed scoreboard bench for md5_result_tx_arbiter (4 cores, 32-bit candidates).
module tb_md5_result_tx_arbiter;

  localparam int NCORES = 4;
  localparam int WORD_W = 32;
`ifdef MD5_RESULT_TX_CHECKSUM_EN
  localparam int FL = WORD_W/8 + 3;
`else
  localparam int FL = WORD_W/8 + 2;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NCORES-1:0]        req;
  logic [NCORES*WORD_W-1:0] cand;
  logic [NCORES-1:0]        ack;
  logic                     rewind_usart;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     busy;
  logic                     tx_led;

  int vectors     = 0;
  int miscompares = 0;
  int frames_sent = 0;
  logic [7:0]        exp_q[$];
  logic [NCORES-1:0] ack_q[$];

  md5_result_tx_arbiter #(.NCORES(NCORES), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .req(req), .cand(cand), .ack(ack),
    .rewind_usart(rewind_usart), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_led(tx_led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Queue the bytes a frame for this core/candidate must produce.
  task automatic pushFrame(input int id, input logic [31:0] c);
`ifdef MD5_RESULT_TX_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'(id);
`endif
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(id));
    for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(c[b*8 +: 8]);
`ifdef MD5_RESULT_TX_CHECKSUM_EN
      cs = cs ^ c[b*8 +: 8];
`endif
    end
`ifdef MD5_RESULT_TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    frames_sent++;
  endtask

  task automatic applyStimulus(input int core, input logic [31:0] c);
    cand[core*WORD_W +: WORD_W] = c;
    req[core] = 1'b1;
    pushFrame(core, c);
  endtask

  task automatic waitDrain(input string tag);
    int left;
    left = 60;
    while (left > 0 && (exp_q.size() != 0 || busy)) begin
      @(posedge clk); #1;
      left--;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_led"}, 32'(tx_led), 32'(frames_sent & 1));
  endtask

  // Byte monitor: every accepted byte is popped from the scoreboard; stalled bytes must hold.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_data", 32'(tx_data), 32'(prev_data));
        checkOutput("hold_valid", 32'(tx_valid), 32'd1);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) checkOutput("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else checkOutput("byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int left;
    reset = 1'b1; req = '0; cand = '0; rewind_usart = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tx_led", 32'(tx_led), 32'd0);
    reset = 1'b0;

    // Round robin: all four request, core 0 re-requests mid-round and must wait for core 3.
    @(posedge clk); #1;
    for (int i = 0; i < NCORES; i++) begin
      applyStimulus(i, 32'h1111_1111 * (i + 1));
      ack_q.push_back(NCORES'(1 << i));
    end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        if (ack_q.size() == 0) checkOutput("rr_extra_grant", 32'(ack), 32'd0);
        else checkOutput("rr_grant", 32'(ack), 32'(ack_q.pop_front()));
        req = req & ~ack;
      end
      if (c == 3) begin
        applyStimulus(0, 32'hCAFE_F00D);
        ack_q.push_back(4'b0001);
      end
      if (c > 3 && ack_q.size() == 0 && exp_q.size() == 0 && !busy) break;
    end
    checkOutput("rr_acks_left", 32'(ack_q.size()), 32'd0);
    waitDrain("rr_drain");

    // Single request, frame must be FL back-to-back valid cycles.
    applyStimulus(0, 32'h1234_5678);
    @(posedge clk); #1;
    checkOutput("single_ack", 32'(ack), 32'b0001);
    checkOutput("single_first_byte", 32'(tx_data), 32'hA5);
    req = '0;
    for (int k = 0; k < FL; k++) begin
      checkOutput("single_valid", 32'(tx_valid), 32'd1);
      if (k == 1) checkOutput("single_ack_pulse", 32'(ack), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("single_end_valid", 32'(tx_valid), 32'd0);
    checkOutput("single_end_busy", 32'(busy), 32'd0);
    waitDrain("single_drain");

    // Rewind together with a request: replay first (no ack), then core 2.
    rewind_usart = 1'b1;
    pushFrame(0, 32'h1234_5678);
    applyStimulus(2, 32'h0BAD_CAFE);
    @(posedge clk); #1;
    rewind_usart = 1'b0;
    checkOutput("rewind_no_ack", 32'(ack), 32'd0);
    checkOutput("rewind_valid", 32'(tx_valid), 32'd1);
    left = 30;
    while (left > 0 && ack == '0) begin
      @(posedge clk); #1;
      left--;
    end
    checkOutput("rewind_then_ack", 32'(ack), 32'b0100);
    checkOutput("rewind_replay_done", 32'(exp_q.size()), 32'(FL));
    req = '0;
    waitDrain("rewind_drain");

    // Backpressure: stall five cycles on the first data byte.
    applyStimulus(1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    checkOutput("bp_ack", 32'(ack), 32'b0010);
    req = '0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("bp_stall_byte", 32'(tx_data), 32'hDE);
    tx_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_byte", 32'(tx_data), 32'hDE);
      checkOutput("bp_hold_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    waitDrain("bp_drain");

    // Reset in the middle of DATA, then a rewind that must be ignored.
    applyStimulus(0, 32'h1234_5678);
    @(posedge clk); #1;
    checkOutput("rst_ack", 32'(ack), 32'b0001);
    req = '0;
    left = 10;
    while (left > 0 && !(tx_valid && tx_data == 8'h34)) begin
      @(posedge clk); #1;
      left--;
    end
    checkOutput("rst_point", 32'(tx_data), 32'h34);
    reset = 1'b1;
    #1;
    checkOutput("rst_ack0", 32'(ack), 32'd0);
    checkOutput("rst_tx_data0", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_valid0", 32'(tx_valid), 32'd0);
    checkOutput("rst_busy0", 32'(busy), 32'd0);
    checkOutput("rst_tx_led0", 32'(tx_led), 32'd0);
    exp_q.delete();
    frames_sent = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    rewind_usart = 1'b1;
    @(posedge clk); #1;
    rewind_usart = 1'b0;
    repeat (4) begin
      checkOutput("rst_rewind_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_rewind_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
